// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - opcode constants shared by the alu4 datapath
package alu4_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - combinational compute of result, carry and status flags
module alu4_core
    import alu4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of diff is the borrow: set exactly when a < b unsigned.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_ADD: begin
                result    = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result    = diff[WIDTH-1:0];
                carry_out = diff[WIDTH];
                overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result    = {a[WIDTH-2:0], 1'b0};
                carry_out = a[WIDTH-1];
            end
            OP_SHR: begin
                result    = {1'b0, a[WIDTH-1:1]};
                carry_out = a[0];
            end
            default: result = '0;
        endcase
        zero     = (result == '0);
        negative = result[WIDTH-1];
    end

endmodule

// File: rtl/alu4.sv
// rtl/alu4.sv - registered ALU: core compute followed by one output register stage
module alu4
    import alu4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_zero;
    logic             core_negative;
    logic             core_overflow;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             overflow_q, overflow_d;

    alu4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (core_result),
        .carry_out (core_carry),
        .zero      (core_zero),
        .negative  (core_negative),
        .overflow  (core_overflow)
    );

    // Result and flags hold across idle cycles; only out_valid tracks in_valid.
    always_comb begin
        valid_d    = in_valid;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        if (in_valid) begin
            result_d   = core_result;
            carry_d    = core_carry;
            zero_d     = core_zero;
            negative_d = core_negative;
            overflow_d = core_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu4.sv
// tb/tb_alu4.sv - directed and random checks of alu4 against a scoreboard model
module tb_alu4;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic [3:0] result;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t last_exp;

    alu4 #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written in plain integer arithmetic, signed range for overflow.
    function automatic exp_t model(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] iop);
        exp_t e;
        int ua, ub, sa, sb, t;
        ua = int'(ia);
        ub = int'(ib);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        e  = '0;
        t  = 0;
        case (iop)
            3'd0: begin t = ua + ub; e.c = (t > 15); e.v = ((sa + sb) > 7) || ((sa + sb) < -8); end
            3'd1: begin t = ua - ub + 16; e.c = (ua < ub); e.v = ((sa - sb) > 7) || ((sa - sb) < -8); end
            3'd2: t = ua & ub;
            3'd3: t = ua | ub;
            3'd4: t = ua ^ ub;
            3'd5: t = 15 - ua;
            3'd6: begin t = ua * 2; e.c = (ua >= 8); end
            default: begin t = ua / 2; e.c = (ua % 2) == 1; end
        endcase
        e.res = 4'(t % 16);
        e.z   = (e.res == 4'd0);
        e.n   = (e.res >= 4'd8);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e, input logic v);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".result"},    32'(result),    32'(e.res));
        check({tag, ".carry"},     32'(carry_out), 32'(e.c));
        check({tag, ".zero"},      32'(zero),      32'(e.z));
        check({tag, ".negative"},  32'(negative),  32'(e.n));
        check({tag, ".overflow"},  32'(overflow),  32'(e.v));
    endtask

    // Drive one valid op, clock it in, then pop the scoreboard and compare.
    task automatic do_op(input string tag, input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] iop);
        exp_t e;
        a        = ia;
        b        = ib;
        op       = iop;
        in_valid = 1'b1;
        exp_q.push_back(model(ia, ib, iop));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
        end else begin
            e = exp_q.pop_front();
            check_all(tag, e, 1'b1);
            last_exp = e;
        end
    endtask

    initial begin
        exp_t zero_exp;
        zero_exp = '0;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        #2;
        check_all("reset", zero_exp, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op("add_ovf",  4'b0101, 4'b0011, 3'b000);
        check("add_ovf.const", 32'(result), 32'b1000);
        do_op("add_wrap", 4'b1111, 4'b0001, 3'b000);
        do_op("sub_ovf",  4'b1000, 4'b0100, 3'b001);
        do_op("sub_brw",  4'b0011, 4'b0101, 3'b001);
        check("sub_brw.const", 32'({carry_out, result}), 32'b11110);
        do_op("and",      4'b1100, 4'b1010, 3'b010);
        do_op("or",       4'b1100, 4'b1010, 3'b011);
        do_op("xor",      4'b1100, 4'b1010, 3'b100);
        do_op("not",      4'b1100, 4'b1010, 3'b101);
        check("not.const", 32'(result), 32'b0011);
        do_op("shl_0",    4'b0011, 4'b0000, 3'b110);
        do_op("shl_1",    4'b1001, 4'b0000, 3'b110);
        do_op("shr_0",    4'b1000, 4'b0000, 3'b111);
        do_op("shr_1",    4'b0001, 4'b0000, 3'b111);
        check("shr_1.const", 32'({carry_out, zero, result}), 32'b110000);

        for (int i = 0; i < 24; i++) begin
            do_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end

        do_op("pre_hold", 4'b0111, 4'b0001, 3'b000);
        in_valid = 1'b0;
        a        = 4'b0000;
        b        = 4'b0000;
        op       = 3'b000;
        @(posedge clk);
        #1;
        check_all("hold1", last_exp, 1'b0);
        @(posedge clk);
        #1;
        check_all("hold2", last_exp, 1'b0);

        do_op("pre_rst", 4'b1111, 4'b1111, 3'b000);
        a        = 4'b0101;
        b        = 4'b0011;
        op       = 3'b000;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_all("async_rst", zero_exp, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", zero_exp, 1'b0);
        exp_q.delete();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", zero_exp, 1'b0);
        do_op("recover", 4'b0010, 4'b0011, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
